snake_head_stepper: RTL and testbench
=====================================

// Module: snake_head_stepper
// PURPOSE
//  Next-state generator for the snake head position; sits directly upstream of the 6-bit head register.
//  Divides clk into game ticks, latches player direction requests from four buttons, rejects 180-degree reversals.
//  On each tick, emits the head coordinate moved one cell with wrap-around on an 8x8 grid.
//  Between ticks, next_pos passes cur_pos through, so a register that loads every clk holds its value.
// PARAMETERS
//  TICK_DIV   25_000_000   clk cycles per game tick; legal range >= 2
//  START_DIR  2'b01        direction after reset (RIGHT)
// PORTS
//  clk        in   1  system clock, rising edge
//  reset      in   1  asynchronous, active-high; clears all state immediately
//  enable     in   1  1 = game running; 0 = tick counter frozen, no steps
//  btn_up     in   1  level; synchronised and debounced upstream
//  btn_right  in   1  as btn_up
//  btn_down   in   1  as btn_up
//  btn_left   in   1  as btn_up
//  cur_pos    in   6  current head {y[2:0],x[2:0]}, taken from the head register output
//  next_pos   out  6  value to load into the head register (combinational from cur_pos/step/pend)
//  step       out  1  registered one-cycle pulse: next_pos is a moved position this cycle
//  dir        out  2  committed direction of travel
// BEHAVIOUR
//  Direction encoding: UP=2'b00, RIGHT=2'b01, DOWN=2'b10, LEFT=2'b11; opposite(d) = d ^ 2'b10.
//  Reset (async): cnt=0, step=0, dir=pend=START_DIR, btn_q=4'b0.
//   A button held through reset deasserts into an edge on the first clk after reset.
//  Tick counter (enable=1): cnt counts 0..TICK_DIV-1 and wraps to 0.
//   step<=1 on the edge where cnt wraps, else step<=0; first step appears TICK_DIV cycles after reset release.
//  enable=0: cnt holds, step<=0; counting resumes from the held value.
//  Button edges: btn_q registers the buttons; rise = btn & ~btn_q.
//   If several rise in the same cycle, priority is UP > RIGHT > DOWN > LEFT; only the winner is considered.
//   Reversal check: let dir_nxt = step ? pend : dir.
//    Winner w is accepted (pend<=w) iff w != opposite(dir_nxt); otherwise pend is unchanged.
//   Later accepted presses before a tick overwrite pend (last press wins).
//  Step cycle (step=1):
//   next_pos = move(cur_pos, pend); dir<=pend on the same edge; the new dir is visible the following cycle.
//  Non-step cycle: next_pos = cur_pos; dir unchanged.
//  move (3-bit modulo arithmetic, wraps both ways):
//   UP: y-1 | DOWN: y+1 | RIGHT: x+1 | LEFT: x-1.
//   Examples: x=7 RIGHT -> 0; y=0 UP -> 7.
//  Latency: button edge to pend = 1 clk; pend to position = next tick.
//  Total latency from press to moved position is at most TICK_DIV+1 cycles.
//  Reset mid-tick: step drops to 0 asynchronously, next_pos = cur_pos immediately, and pending requests are lost.
// STRUCTURE
//  Shared include snake_defs.vh: DIR_UP/RIGHT/DOWN/LEFT localparams, GRID_BITS=3, POS_W=6, pos field macros.
//  Sub-module tick_divider (params DIV; ports clk, reset, enable, tick) holds the counter and step register.
//  Everything else (edge detect, direction FSM, move logic) stays in this module.
// TESTING (TICK_DIV=4; cur_pos looped back through the head register, reset value 6'b011_011)
//  1. Release reset, enable=1, no buttons -> step at cycles 4, 8, 12; pos 011_100, 011_101, 011_110; dir=01.
//  2. Head register at x=7, dir RIGHT, one tick -> pos x=0, y unchanged; repeat with y=0 and UP -> y=7.
//  3. dir RIGHT, pulse btn_left -> pend stays RIGHT, next step x+1.
//     Then pulse btn_up -> next step y-1 and dir=00 one cycle after step.
//  4. dir RIGHT, btn_up and btn_down rise in the same cycle -> pend=UP.
//     Also: btn_down rises on a step edge committing UP -> rejected.
//  5. enable=0 for 10 cycles mid-count -> step stays 0 and next_pos==cur_pos; step resumes after the remaining count.
//  6. Assert reset between clk edges mid-count -> step=0 and dir=01 before the next clk edge.
//     After release, first step occurs 4 cycles later.

Source files
------------

// File: rtl/snake_head_stepper_pkg.sv
// Shared types and helpers for the snake head stepper: direction encoding,
// grid geometry and the wrap-around move on the 8x8 board.
package snake_head_stepper_pkg;

  localparam int GRID_BITS = 3;
  localparam int POS_W     = 2 * GRID_BITS;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  function automatic dir_e opposite(input dir_e d);
    return dir_e'(d ^ 2'b10);
  endfunction

  // Position is {y, x}; both fields wrap modulo the grid size.
  function automatic logic [POS_W-1:0] move_pos(input logic [POS_W-1:0] pos,
                                                input dir_e d);
    logic [GRID_BITS-1:0] x;
    logic [GRID_BITS-1:0] y;
    y = pos[POS_W-1:GRID_BITS];
    x = pos[GRID_BITS-1:0];
    unique case (d)
      DIR_UP:    y = y - GRID_BITS'(1);
      DIR_DOWN:  y = y + GRID_BITS'(1);
      DIR_RIGHT: x = x + GRID_BITS'(1);
      DIR_LEFT:  x = x - GRID_BITS'(1);
    endcase
    return {y, x};
  endfunction

endpackage

// File: rtl/snake_head_stepper_tick_divider.sv
// Game-tick divider: counts enabled clk cycles 0..DIV-1 and emits a registered
// one-cycle tick on the wrap edge; the count freezes while enable is low.
module snake_head_stepper_tick_divider #(
  parameter int DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int                CNT_W   = $clog2(DIV);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (enable) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/snake_head_stepper.sv
// Next-state generator for the snake head register: latches button requests,
// rejects reversals, and moves the head one cell on each game tick.
module snake_head_stepper
  import snake_head_stepper_pkg::*;
#(
  parameter int         TICK_DIV  = 25_000_000,
  parameter logic [1:0] START_DIR = 2'b01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             btn_up,
  input  logic             btn_right,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic [POS_W-1:0] cur_pos,
  output logic [POS_W-1:0] next_pos,
  output logic             step,
  output logic [1:0]       dir
);

  logic [3:0] btn, btn_q, btn_d, rise;
  dir_e       dir_q, dir_d, pend_q, pend_d;
  dir_e       win, dir_nxt;
  logic       win_vld;

  snake_head_stepper_tick_divider #(.DIV(TICK_DIV)) u_tick_divider (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (step)
  );

  assign btn  = {btn_up, btn_right, btn_down, btn_left};
  assign rise = btn & ~btn_q;

  always_comb begin
    win_vld = |rise;
    win     = DIR_UP;
    if (rise[3])      win = DIR_UP;
    else if (rise[2]) win = DIR_RIGHT;
    else if (rise[1]) win = DIR_DOWN;
    else if (rise[0]) win = DIR_LEFT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_q  <= 4'b0;
      dir_q  <= dir_e'(START_DIR);
      pend_q <= dir_e'(START_DIR);
    end else begin
      btn_q  <= btn_d;
      dir_q  <= dir_d;
      pend_q <= pend_d;
    end
  end

  // On a step edge the pending direction becomes the committed one, so
  // reversal is judged against what dir will be after this edge.
  always_comb begin
    btn_d   = btn;
    dir_nxt = step ? pend_q : dir_q;
    dir_d   = dir_nxt;
    pend_d  = pend_q;
    if (win_vld && (win != opposite(dir_nxt))) pend_d = win;
  end

  always_comb begin
    next_pos = step ? move_pos(cur_pos, pend_q) : cur_pos;
    dir      = dir_q;
  end

endmodule

// File: tb/tb_snake_head_stepper.sv
// Self-checking bench for snake_head_stepper with the head register looped back.
module tb_snake_head_stepper;

  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       btn_up = 1'b0, btn_right = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
  logic [5:0] head;
  logic [5:0] next_pos;
  logic       step;
  logic [1:0] dir;

  int n_chk = 0;
  int n_pass = 0;
  int ecnt = 0;
  bit checking = 1'b0;

  snake_head_stepper #(.TICK_DIV(TICK_DIV), .START_DIR(2'b01)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .btn_up    (btn_up),
    .btn_right (btn_right),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .cur_pos   (head),
    .next_pos  (next_pos),
    .step      (step),
    .dir       (dir)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) head <= 6'b011_011;
    else       head <= next_pos;
  end

  // Behavioural model: position as integer y*8+x, directions 0..3.
  int       m_pos, m_dir, m_pend, m_ticks, mw, mbase, mnew;
  bit       m_step;
  bit [3:0] m_prev, mb;

  function automatic int mv(input int pos, input int d);
    int x, y;
    x = pos % 8;
    y = pos / 8;
    case (d)
      0: y = (y + 7) % 8;
      1: x = (x + 1) % 8;
      2: y = (y + 1) % 8;
      default: x = (x + 7) % 8;
    endcase
    return y * 8 + x;
  endfunction

  function automatic int exp_next();
    return m_step ? mv(m_pos, m_pend) : m_pos;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pos = 27; m_dir = 1; m_pend = 1; m_ticks = 0; m_step = 0; m_prev = '0;
    end else begin
      mb = {btn_left, btn_down, btn_right, btn_up};
      mw = -1;
      for (int i = 3; i >= 0; i--) if (mb[i] && !m_prev[i]) mw = i;
      mbase = m_step ? m_pend : m_dir;
      mnew  = exp_next();
      m_pos = mnew;
      m_dir = mbase;
      if (mw >= 0 && mw != (mbase ^ 2)) m_pend = mw;
      if (enable) begin
        m_ticks++;
        m_step = (m_ticks % TICK_DIV) == 0;
      end else begin
        m_step = 0;
      end
      m_prev = mb;
    end
  end

  task automatic check(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp_v, $time);
  endtask

  always @(negedge clk) begin
    if (checking && !reset) begin
      check("step", int'(step), int'(m_step));
      check("dir", int'(dir), m_dir);
      check("next_pos", int'(next_pos), exp_next());
      check("head", int'(head), m_pos);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  task automatic run_to(input int n);
    while (ecnt < n) cyc();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) cyc();
    check("rst_step", int'(step), 0);
    check("rst_dir", int'(dir), 1);
    check("rst_next_pos", int'(next_pos), 6'b011_011);
    enable = 1'b1;
    reset = 1'b0;
    checking = 1'b1;
    ecnt = 0;

    // Free-running steps to the right
    run_to(3);  check("t1_no_step_early", int'(step), 0);
    run_to(4);  check("t1_step4", int'(step), 1);
    check("t1_pos4", int'(next_pos), 6'b011_100);
    run_to(8);  check("t1_pos8", int'(next_pos), 6'b011_101);
    run_to(12); check("t1_pos12", int'(next_pos), 6'b011_110);
    check("t1_dir", int'(dir), 1);

    // Reversal rejected, then a turn up
    run_to(13); btn_left = 1'b1;
    run_to(14); btn_left = 1'b0;
    run_to(16); check("t3_left_rejected", int'(next_pos), 6'b011_111);
    run_to(17); btn_up = 1'b1;
    run_to(18); btn_up = 1'b0;
    run_to(20); check("t3_up_pos", int'(next_pos), 6'b010_111);
    check("t3_dir_before", int'(dir), 1);
    run_to(21); check("t3_dir_after", int'(dir), 0);

    // Wrap in y going up, then in x going right
    run_to(24); check("t2_pos24", int'(next_pos), 6'b001_111);
    run_to(28); check("t2_pos28", int'(next_pos), 6'b000_111);
    run_to(32); check("t2_ywrap", int'(next_pos), 6'b111_111);
    run_to(33); btn_right = 1'b1;
    run_to(34); btn_right = 1'b0;
    run_to(36); check("t2_xwrap", int'(next_pos), 6'b111_000);
    run_to(37); check("t2_dir_right", int'(dir), 1);

    // Simultaneous up+down: up wins; down on the step edge committing up is rejected
    btn_up = 1'b1; btn_down = 1'b1;
    run_to(38); btn_up = 1'b0; btn_down = 1'b0;
    run_to(40); check("t4_prio_up", int'(next_pos), 6'b110_000);
    btn_down = 1'b1;
    run_to(41); btn_down = 1'b0;
    check("t4_dir_up", int'(dir), 0);
    run_to(44); check("t4_down_rejected", int'(next_pos), 6'b101_000);

    // Enable low freezes the tick count
    run_to(46); enable = 1'b0;
    run_to(50); check("t5_hold_step", int'(step), 0);
    check("t5_hold_pos", int'(next_pos), int'(head));
    run_to(56); enable = 1'b1;
    run_to(57); check("t5_resume_wait", int'(step), 0);
    run_to(58); check("t5_resume_step", int'(step), 1);

    // Asynchronous reset between edges
    run_to(60);
    #2 reset = 1'b1;
    #1;
    check("t6_async_step", int'(step), 0);
    check("t6_async_dir", int'(dir), 1);
    check("t6_async_pos", int'(next_pos), int'(head));
    cyc(); cyc();
    reset = 1'b0;
    ecnt = 0;
    run_to(3); check("t6_no_step3", int'(step), 0);
    run_to(4); check("t6_step4", int'(step), 1);
    check("t6_pos4", int'(next_pos), 6'b011_100);

    // Randomized play
    for (int c = 0; c < 3000; c++) begin
      cyc();
      btn_up    = ($urandom_range(0, 5) == 0);
      btn_right = ($urandom_range(0, 5) == 0);
      btn_down  = ($urandom_range(0, 5) == 0);
      btn_left  = ($urandom_range(0, 5) == 0);
      enable    = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b1;
        cyc();
        reset = 1'b0;
      end
    end

    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
